pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Pipeline control unit for the 8-bit 5-stage core. Drives stall and flush for the IF/ID and ID/EX registers and the PC.
//  Covers load-use stalls, taken-branch squash and the multi-cycle interrupt entry sequence (drain, push PC, vector).
//  Sits beside the decode stage and observes ID/EX control outputs plus the branch resolution from EX.
// PARAMETERS
//  LOAD_STALL_CYC  1  bubbles inserted per load-use hazard (1..3)
//  DRAIN_CYC       2  cycles spent in INT_DRAIN so older instructions retire (1..3)
//  RIDX_W          2  register index width
// PORTS
//  clk               in   1       clock, rising edge
//  rst               in   1       asynchronous reset, active-high
//  id_ex_MemRead     in   1       instruction in EX is a load
//  id_ex_RegDistidx  in   RIDX_W  destination register of instruction in EX
//  if_id_ra          in   RIDX_W  source A of instruction in ID
//  if_id_rb          in   RIDX_W  source B of instruction in ID
//  if_id_use_ra      in   1       ID instruction reads ra
//  if_id_use_rb      in   1       ID instruction reads rb
//  br_taken          in   1       EX resolved a taken branch/jump this cycle
//  intr_req          in   1       external interrupt request, level
//  int_en            in   1       global interrupt enable
//  pc_write          out  1       PC load enable
//  if_id_write       out  1       IF/ID load enable (0 = hold)
//  if_id_flush       out  1       IF/ID -> NOP
//  id_ex_flush       out  1       ID/EX controls -> 0 (drives its flush pin)
//  pc_src            out  2       00 PC+1, 01 branch target, 10 interrupt vector
//  int_push          out  1       write current PC to stack (SP-- in MEM)
//  int_ack           out  1       one-cycle acknowledge to interrupt source
//  busy              out  1       FSM not in RUN
// BEHAVIOUR
//  - State is registered; outputs are combinational decode of state plus inputs.
//  - While rst=1: state=RUN, counters 0, int_pend=0.
//  - While rst=1, outputs are forced: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_flush=1, pc_src=00, int_push=0, int_ack=0, busy=0.
//  - Reset mid-sequence aborts to RUN with no push/ack.
//  - load_use = id_ex_MemRead & ((if_id_use_ra & ra==dst) | (if_id_use_rb & rb==dst)).
//  - int_pend: set on any clk with intr_req&int_en; cleared the cycle int_ack=1; an int_ack cycle with intr_req still high re-arms it.
//  - Default (RUN, no event): pc_write=1, if_id_write=1, flushes 0, pc_src=00.
//  - RUN, priority: br_taken > load_use > int_pend.
//    br_taken: pc_src=01, pc_write=1, if_id_flush=1, id_ex_flush=1; stay RUN; any load_use is ignored.
//    load_use: pc_write=0, if_id_write=0, id_ex_flush=1. If LOAD_STALL_CYC>1 -> STALL with cnt=LOAD_STALL_CYC-1.
//    int_pend: -> INT_DRAIN, cnt=DRAIN_CYC. Entry cycle already holds PC and flushes IF/ID.
//  - STALL: same outputs as the load_use stall; cnt--; at cnt==1 -> RUN. br_taken overrides: RUN branch outputs, -> RUN.
//  - INT_DRAIN: pc_write=0, if_id_flush=1, id_ex_flush=1 (no new instr enters EX); cnt--; cnt==1 -> INT_PUSH.
//    If br_taken here: pc_src=01, pc_write=1 so the saved PC equals the branch target.
//  - INT_PUSH: 1 cycle; int_push=1, pc_write=0, both flushes=1 -> INT_VEC.
//  - INT_VEC: 1 cycle; pc_src=10, pc_write=1, if_id_flush=1, int_ack=1 -> RUN.
//  - Interrupt entry latency: DRAIN_CYC+2 cycles from leaving RUN to first vector fetch.
//  - intr_req/int_en changes after INT_DRAIN entry do not abort the sequence.
//  - busy=1 in STALL, INT_DRAIN, INT_PUSH, INT_VEC.
//  - Counters are 2-bit, saturate at 0, never wrap.
// STRUCTURE
//  - pipe_ctrl_pkg: state encoding (RUN, STALL, INT_DRAIN, INT_PUSH, INT_VEC).
//  - pipe_ctrl_pkg: PC_SRC_SEQ/BR/VEC constants, shared with the PC mux.
//  - Sub-module load_use_detect: combinational compare producing load_use.
//  - Top holds the FSM, counter and int_pend.
// TESTING
//  1. rst=1 mid-INT_PUSH -> next cycle int_push=0, both flushes=1, pc_write=0; after release state RUN, busy=0.
//  2. id_ex_MemRead=1, dst=2, if_id_rb=2, use_rb=1 -> exactly LOAD_STALL_CYC cycles of pc_write=0, if_id_write=0, id_ex_flush=1; then normal.
//  3. load_use and br_taken same cycle -> pc_src=01, both flushes=1, pc_write=1, no stall cycle follows.
//  4. intr_req=1, int_en=1, DRAIN_CYC=2 -> INT_DRAIN x2, int_push one cycle, then pc_src=10 with int_ack=1, back in RUN; intr_req=1 with int_en=0 -> never busy.
//  5. br_taken in 1st INT_DRAIN cycle -> pc_write=1, pc_src=01 that cycle; sequence still completes with int_push 1 cycle later.
//  6. intr_req held high through int_ack -> second entry starts the cycle after RUN resumes.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared state encoding and PC mux select codes
package pipe_hazard_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RUN       = 3'd0,
        ST_STALL     = 3'd1,
        ST_INT_DRAIN = 3'd2,
        ST_INT_PUSH  = 3'd3,
        ST_INT_VEC   = 3'd4
    } state_t;

    typedef logic [1:0] pc_src_t;

    // PC mux select codes, shared with the PC mux in the fetch stage
    localparam pc_src_t PC_SRC_SEQ = 2'b00;
    localparam pc_src_t PC_SRC_BR  = 2'b01;
    localparam pc_src_t PC_SRC_VEC = 2'b10;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - pipeline observation inputs and control outputs of the hazard unit
interface pipe_hazard_ctrl_if
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int RIDX_W = 2
);
    logic              id_ex_MemRead;
    logic [RIDX_W-1:0] id_ex_RegDistidx;
    logic [RIDX_W-1:0] if_id_ra;
    logic [RIDX_W-1:0] if_id_rb;
    logic              if_id_use_ra;
    logic              if_id_use_rb;
    logic              br_taken;
    logic              intr_req;
    logic              int_en;

    logic              pc_write;
    logic              if_id_write;
    logic              if_id_flush;
    logic              id_ex_flush;
    pc_src_t           pc_src;
    logic              int_push;
    logic              int_ack;
    logic              busy;

    // pipeline side: presents stage state, consumes control
    modport master (
        output id_ex_MemRead, id_ex_RegDistidx, if_id_ra, if_id_rb,
               if_id_use_ra, if_id_use_rb, br_taken, intr_req, int_en,
        input  pc_write, if_id_write, if_id_flush, id_ex_flush,
               pc_src, int_push, int_ack, busy
    );

    // hazard controller side
    modport slave (
        input  id_ex_MemRead, id_ex_RegDistidx, if_id_ra, if_id_rb,
               if_id_use_ra, if_id_use_rb, br_taken, intr_req, int_en,
        output pc_write, if_id_write, if_id_flush, id_ex_flush,
               pc_src, int_push, int_ack, busy
    );

endinterface

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// rtl/pipe_hazard_ctrl_load_use_detect.sv - load-use hazard compare between EX destination and ID sources
module pipe_hazard_ctrl_load_use_detect #(
    parameter int RIDX_W = 2
) (
    input  logic              i_mem_read,
    input  logic [RIDX_W-1:0] i_dst,
    input  logic [RIDX_W-1:0] i_ra,
    input  logic [RIDX_W-1:0] i_rb,
    input  logic              i_use_ra,
    input  logic              i_use_rb,
    output logic              o_load_use
);

    // A source only matters when the ID instruction actually reads it
    assign o_load_use = i_mem_read &
                        ((i_use_ra & (i_ra == i_dst)) |
                         (i_use_rb & (i_rb == i_dst)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush/PC control FSM for load-use, branch squash and interrupt entry
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int LOAD_STALL_CYC = 1,
    parameter int DRAIN_CYC      = 2,
    parameter int RIDX_W         = 2
) (
    input  logic                clk,
    input  logic                rst,
    pipe_hazard_ctrl_if.slave   bus
);

    localparam logic [1:0] STALL_RELOAD = 2'(LOAD_STALL_CYC - 1);
    localparam logic [1:0] DRAIN_RELOAD = 2'(DRAIN_CYC);

    state_t     r_state;
    state_t     w_next_state;
    logic [1:0] r_cnt;
    logic [1:0] w_next_cnt;
    logic [1:0] w_cnt_dec;
    logic       r_int_pend;
    logic       w_int_req;
    logic       w_load_use;

    logic       w_pc_write;
    logic       w_if_id_write;
    logic       w_if_id_flush;
    logic       w_id_ex_flush;
    pc_src_t    w_pc_src;
    logic       w_int_push;
    logic       w_int_ack;
    logic       w_busy;

    pipe_hazard_ctrl_load_use_detect #(
        .RIDX_W (RIDX_W)
    ) u_load_use_detect (
        .i_mem_read (bus.id_ex_MemRead),
        .i_dst      (bus.id_ex_RegDistidx),
        .i_ra       (bus.if_id_ra),
        .i_rb       (bus.if_id_rb),
        .i_use_ra   (bus.if_id_use_ra),
        .i_use_rb   (bus.if_id_use_rb),
        .o_load_use (w_load_use)
    );

    assign w_int_req = bus.intr_req & bus.int_en;
    assign w_cnt_dec = (r_cnt != 2'd0) ? (r_cnt - 2'd1) : 2'd0;

    // Next-state and output decode; reset overrides everything at the end
    always_comb begin
        w_next_state  = r_state;
        w_next_cnt    = r_cnt;
        w_pc_write    = 1'b1;
        w_if_id_write = 1'b1;
        w_if_id_flush = 1'b0;
        w_id_ex_flush = 1'b0;
        w_pc_src      = PC_SRC_SEQ;
        w_int_push    = 1'b0;
        w_int_ack     = 1'b0;
        w_busy        = (r_state != ST_RUN);

        case (r_state)
            ST_RUN: begin
                if (bus.br_taken) begin
                    w_pc_src      = PC_SRC_BR;
                    w_if_id_flush = 1'b1;
                    w_id_ex_flush = 1'b1;
                end else if (w_load_use) begin
                    w_pc_write    = 1'b0;
                    w_if_id_write = 1'b0;
                    w_id_ex_flush = 1'b1;
                    if (LOAD_STALL_CYC > 1) begin
                        w_next_state = ST_STALL;
                        w_next_cnt   = STALL_RELOAD;
                    end
                end else if (r_int_pend) begin
                    // the ID instruction still advances into EX; fetch is held and squashed
                    w_pc_write    = 1'b0;
                    w_if_id_flush = 1'b1;
                    w_next_state  = ST_INT_DRAIN;
                    w_next_cnt    = DRAIN_RELOAD;
                end
            end
            ST_STALL: begin
                if (bus.br_taken) begin
                    w_pc_src      = PC_SRC_BR;
                    w_if_id_flush = 1'b1;
                    w_id_ex_flush = 1'b1;
                    w_next_state  = ST_RUN;
                    w_next_cnt    = 2'd0;
                end else begin
                    w_pc_write    = 1'b0;
                    w_if_id_write = 1'b0;
                    w_id_ex_flush = 1'b1;
                    w_next_cnt    = w_cnt_dec;
                    if (r_cnt <= 2'd1) w_next_state = ST_RUN;
                end
            end
            ST_INT_DRAIN: begin
                w_pc_write    = 1'b0;
                w_if_id_flush = 1'b1;
                w_id_ex_flush = 1'b1;
                // a late branch redirects the PC so the pushed return address is its target
                if (bus.br_taken) begin
                    w_pc_src   = PC_SRC_BR;
                    w_pc_write = 1'b1;
                end
                w_next_cnt = w_cnt_dec;
                if (r_cnt <= 2'd1) w_next_state = ST_INT_PUSH;
            end
            ST_INT_PUSH: begin
                w_int_push    = 1'b1;
                w_pc_write    = 1'b0;
                w_if_id_flush = 1'b1;
                w_id_ex_flush = 1'b1;
                w_next_state  = ST_INT_VEC;
            end
            ST_INT_VEC: begin
                w_pc_src      = PC_SRC_VEC;
                w_if_id_flush = 1'b1;
                w_int_ack     = 1'b1;
                w_next_state  = ST_RUN;
            end
            default: begin
                w_next_state = ST_RUN;
                w_next_cnt   = 2'd0;
            end
        endcase

        if (rst) begin
            w_pc_write    = 1'b0;
            w_if_id_write = 1'b0;
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
            w_pc_src      = PC_SRC_SEQ;
            w_int_push    = 1'b0;
            w_int_ack     = 1'b0;
            w_busy        = 1'b0;
        end
    end

    // State, counter and pending-interrupt registers; ack clears pending unless still requested
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_cnt      <= 2'd0;
            r_int_pend <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_cnt      <= w_next_cnt;
            r_int_pend <= w_int_ack ? w_int_req : (r_int_pend | w_int_req);
        end
    end

    assign bus.pc_write    = w_pc_write;
    assign bus.if_id_write = w_if_id_write;
    assign bus.if_id_flush = w_if_id_flush;
    assign bus.id_ex_flush = w_id_ex_flush;
    assign bus.pc_src      = w_pc_src;
    assign bus.int_push    = w_int_push;
    assign bus.int_ack     = w_int_ack;
    assign bus.busy        = w_busy;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_chk;

    pipe_hazard_ctrl_if #(.RIDX_W(2)) bus ();

    pipe_hazard_ctrl #(
        .LOAD_STALL_CYC (2),
        .DRAIN_CYC      (2),
        .RIDX_W         (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_write, if_id_write, if_id_flush, id_ex_flush, pc_src[1:0], int_push, int_ack, busy}
    localparam logic [8:0] O_RST      = 9'b0_0_1_1_00_0_0_0;
    localparam logic [8:0] O_RUN      = 9'b1_1_0_0_00_0_0_0;
    localparam logic [8:0] O_LU_RUN   = 9'b0_0_0_1_00_0_0_0;
    localparam logic [8:0] O_LU_STALL = 9'b0_0_0_1_00_0_0_1;
    localparam logic [8:0] O_BR       = 9'b1_1_1_1_01_0_0_0;
    localparam logic [8:0] O_BR_STALL = 9'b1_1_1_1_01_0_0_1;
    localparam logic [8:0] O_INT_ENT  = 9'b0_1_1_0_00_0_0_0;
    localparam logic [8:0] O_DRAIN    = 9'b0_1_1_1_00_0_0_1;
    localparam logic [8:0] O_DRAIN_BR = 9'b1_1_1_1_01_0_0_1;
    localparam logic [8:0] O_PUSH     = 9'b0_1_1_1_00_1_0_1;
    localparam logic [8:0] O_VEC      = 9'b1_1_1_0_10_0_1_1;

    task automatic chk(input string tag, input logic [8:0] exp);
        logic [8:0] obs;
        obs = {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_flush,
               bus.pc_src, bus.int_push, bus.int_ack, bus.busy};
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.id_ex_MemRead    = 1'b0;
        bus.id_ex_RegDistidx = 2'd0;
        bus.if_id_ra         = 2'd0;
        bus.if_id_rb         = 2'd0;
        bus.if_id_use_ra     = 1'b0;
        bus.if_id_use_rb     = 1'b0;
        bus.br_taken         = 1'b0;
        bus.intr_req         = 1'b0;
        bus.int_en           = 1'b0;
    endtask

    initial begin
        n_pass = 0;
        n_chk  = 0;
        rst    = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", O_RST);
        rst = 1'b0;
        #1;
        chk("run_idle", O_RUN);

        // load-use on rb: two stall cycles, then normal flow
        tick(); bus.id_ex_MemRead = 1'b1; bus.id_ex_RegDistidx = 2'd2;
        bus.if_id_rb = 2'd2; bus.if_id_use_rb = 1'b1; #1;
        chk("lu_rb_cyc1", O_LU_RUN);
        tick(); bus.id_ex_MemRead = 1'b0; #1;
        chk("lu_rb_cyc2", O_LU_STALL);
        tick(); #1;
        chk("lu_rb_done", O_RUN);

        // ra matches but is not read: no hazard
        tick(); bus.id_ex_MemRead = 1'b1; bus.id_ex_RegDistidx = 2'd1;
        bus.if_id_ra = 2'd1; bus.if_id_use_ra = 1'b0; bus.if_id_rb = 2'd3; #1;
        chk("lu_ra_unused", O_RUN);
        bus.if_id_use_ra = 1'b1; #1;
        chk("lu_ra_cyc1", O_LU_RUN);
        // branch during the STALL state overrides and returns to RUN
        tick(); bus.id_ex_MemRead = 1'b0; bus.if_id_use_ra = 1'b0; bus.br_taken = 1'b1; #1;
        chk("stall_branch", O_BR_STALL);
        tick(); bus.br_taken = 1'b0; #1;
        chk("stall_branch_exit", O_RUN);

        // load-use and taken branch together: branch wins, no stall follows
        tick(); bus.id_ex_MemRead = 1'b1; bus.id_ex_RegDistidx = 2'd2;
        bus.if_id_rb = 2'd2; bus.if_id_use_rb = 1'b1; bus.br_taken = 1'b1; #1;
        chk("lu_with_branch", O_BR);
        tick(); idle(); #1;
        chk("lu_branch_no_stall", O_RUN);

        // interrupt requested while disabled: never enters the sequence
        bus.intr_req = 1'b1; #1;
        chk("int_dis_c0", O_RUN);
        tick(); #1;
        chk("int_dis_c1", O_RUN);
        tick(); #1;
        chk("int_dis_c2", O_RUN);

        // enabled interrupt: entry, drain x2, push, vector, back to RUN
        bus.int_en = 1'b1; #1;
        chk("int_arm", O_RUN);
        tick(); bus.intr_req = 1'b0; #1;
        chk("int_entry", O_INT_ENT);
        tick(); chk("int_drain1", O_DRAIN);
        tick(); chk("int_drain2", O_DRAIN);
        tick(); chk("int_push", O_PUSH);
        tick(); chk("int_vec", O_VEC);
        tick(); chk("int_done", O_RUN);
        tick(); chk("int_no_rearm", O_RUN);

        // branch in the first drain cycle redirects the PC; sequence still completes
        bus.intr_req = 1'b1;
        tick(); bus.intr_req = 1'b0; #1;
        chk("br_int_entry", O_INT_ENT);
        tick(); bus.br_taken = 1'b1; #1;
        chk("drain_branch", O_DRAIN_BR);
        tick(); bus.br_taken = 1'b0; #1;
        chk("drain_after_branch", O_DRAIN);
        tick(); chk("br_int_push", O_PUSH);
        tick(); chk("br_int_vec", O_VEC);
        tick(); chk("br_int_done", O_RUN);

        // request held high through the acknowledge re-arms immediately
        bus.intr_req = 1'b1;
        tick(); chk("hold_entry", O_INT_ENT);
        tick(); chk("hold_drain1", O_DRAIN);
        tick(); chk("hold_drain2", O_DRAIN);
        tick(); chk("hold_push", O_PUSH);
        tick(); chk("hold_vec", O_VEC);
        tick(); bus.intr_req = 1'b0; #1;
        chk("rearm_entry", O_INT_ENT);
        tick(); chk("rearm_drain1", O_DRAIN);
        tick(); chk("rearm_drain2", O_DRAIN);
        tick(); chk("rearm_push", O_PUSH);

        // asynchronous reset in the middle of INT_PUSH aborts the sequence
        rst = 1'b1; #1;
        chk("rst_mid_push", O_RST);
        tick(); chk("rst_held", O_RST);
        rst = 1'b0; #1;
        chk("rst_release", O_RUN);
        tick(); chk("rst_no_pend", O_RUN);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
